// File: rtl/viterbi_traceback.sv
// Survivor-path traceback for the K=3 (4-state) Viterbi decoder: stores decision
// vectors per trellis step, traces back from the chosen end state, emits bits in order.
module viterbi_traceback #(
    parameter int DEPTH      = 16,
    parameter int MW         = 8,
    parameter bit TERMINATED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st,
    input  logic          dec_valid,
    input  logic [3:0]    dec_in,
    input  logic          last,
    input  logic [MW-1:0] pm0,
    input  logic [MW-1:0] pm1,
    input  logic [MW-1:0] pm2,
    input  logic [MW-1:0] pm3,
    output logic          bit_out,
    output logic          bit_valid,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int IW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [NW-1:0] NFULL = NW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_SELECT, S_TRACE, S_OUTPUT, S_DONE
    } state_t;

    state_t           fsm;
    logic [3:0]       mem [DEPTH];
    logic [DEPTH-1:0] bits;
    logic [NW-1:0]    n;
    logic [NW-1:0]    n_m1;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    j;
    logic [IW-1:0]    j_nx;
    logic [IW-1:0]    last_idx;
    logic [1:0]       cur;
    logic [1:0]       min_st;
    logic [MW-1:0]    m01, m23;
    logic [1:0]       i01, i23;

    assign n_m1     = n - NW'(1);
    assign last_idx = n_m1[IW-1:0];
    assign j_nx     = j + IW'(1);

    // Strict less-than at both levels keeps the lower index on ties.
    always_comb begin
        i01    = 2'd0;
        m01    = pm0;
        i23    = 2'd2;
        m23    = pm2;
        min_st = 2'd0;
        if (pm1 < pm0) begin
            i01 = 2'd1;
            m01 = pm1;
        end
        if (pm3 < pm2) begin
            i23 = 2'd3;
            m23 = pm3;
        end
        min_st = (m23 < m01) ? i23 : i01;
    end

    always_ff @(posedge clk) begin
        if (fsm == S_COLLECT && dec_valid && n != NFULL)
            mem[n[IW-1:0]] <= dec_in;
        if (fsm == S_TRACE)
            bits[idx] <= cur[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= S_IDLE;
            n         <= '0;
            idx       <= '0;
            j         <= '0;
            cur       <= 2'd0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (st) begin
                        fsm  <= S_COLLECT;
                        n    <= '0;
                        err  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (dec_valid) begin
                        if (n != NFULL) n <= n + NW'(1);
                        else            err <= 1'b1;
                        if (last) fsm <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    cur <= TERMINATED ? 2'd0 : min_st;
                    idx <= last_idx;
                    fsm <= S_TRACE;
                end
                S_TRACE: begin
                    cur <= {cur[0], mem[idx][cur]};
                    if (idx == '0) begin
                        // bits[0] lands this same edge, so forward it straight out
                        fsm       <= S_OUTPUT;
                        j         <= '0;
                        bit_out   <= cur[1];
                        bit_valid <= 1'b1;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (j == last_idx) begin
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        done      <= 1'b1;
                        fsm       <= S_DONE;
                    end else begin
                        j       <= j_nx;
                        bit_out <= bits[j_nx];
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    fsm  <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/viterbi_traceback.md
# viterbi_traceback

Survivor-path traceback stage of the rate-1/2, K=3 (4-state) Viterbi decoder, directly downstream of `compute_path_metric`. For every trellis step it stores the 4-bit survivor decision vector produced by the add-compare-select stage. At end of frame it selects the start state from the final 8-bit path metrics, traces back through the stored decisions, and emits the decoded bits in forward (transmission) order, one per cycle.

## Interface
- DEPTH, 16, maximum frame length in trellis steps (decision vectors stored), 2..64
- MW, 8, path-metric width
- TERMINATED, 0, 1 = traceback always starts from state 0 (zero-tailed frames); 0 = start from minimum-metric state

- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, asynchronous, active-low
- st  in  1  start-of-frame pulse; sampled only in IDLE
- dec_valid  in  1  dec_in/last valid this cycle
- dec_in  in  4  survivor decision per state; bit s = low bit of predecessor of state s
- last  in  1  qualifies dec_valid: final step of frame
- pm0..pm3  in  MW each  final path metrics; sampled in SELECT
- bit_out  out  1  decoded bit
- bit_valid  out  1  bit_out valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last decoded bit
- err  out  1  sticky overflow flag; cleared on accepted st

## Operation
- Trellis convention: state s = {u_t, u_(t-1)}; predecessor of s = {s[0], dec[s]}; decoded bit at a step = s[1] of the traced state.
- FSM states: IDLE, COLLECT, SELECT, TRACE, OUTPUT, DONE.
- IDLE: st=1 -> COLLECT, write count n=0, err=0. dec_valid in IDLE is ignored.
- COLLECT: each dec_valid writes dec_in to mem[n], n++. dec_valid with last=1 -> SELECT (that vector is stored). If n==DEPTH and dec_valid arrives, the vector is dropped and err=1; a dropped vector with last=1 still -> SELECT with N=DEPTH.
- SELECT (1 cycle): start state = 0 if TERMINATED, else index of minimum of pm0..pm3, unsigned compare, lowest index on tie. idx=N-1.
- TRACE (N cycles): buf[idx]=state[1]; state={state[0], mem[idx][state]}; idx--. Exit at idx==0 -> OUTPUT, j=0.
- OUTPUT (N cycles): bit_out=buf[j], bit_valid=1, j++; after j==N-1 -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- st outside IDLE is ignored. dec_valid outside COLLECT is ignored.
- Reset (any time, including mid-frame): FSM=IDLE; n, idx, j, state = 0; bit_out=0, bit_valid=0, busy=0, done=0, err=0. Memory and buf contents are not reset and are don't-care.

## Timing
- All outputs are registered.
- With the last decision accepted at edge E: SELECT occupies cycle E+1 and TRACE occupies E+2..E+N+1. The first bit_valid is at cycle E+N+2, and bit_valid stays high for exactly N consecutive cycles. done is at cycle E+2N+2, and busy drops in the same cycle done drops.
- Frame length N=1: TRACE 1 cycle, OUTPUT 1 cycle.
- A new st is accepted no earlier than the cycle after done.
- No back-pressure: the consumer must take bit_out every cycle bit_valid is high.

## Test plan
- Reset: assert rst low mid-OUTPUT -> bit_valid, busy, done, err go to 0 immediately. After release, the block idles until st.
- All-zero frame: N=8, dec_in=4'b0000 every step, pm0=0, pm1..pm3=10 -> eight 0 bits, done at E+18.
- Known path: N=6, dec_in sequence 0000, 0000, 0100, 0000, 0010, 0001 (last on sixth), pm0=0, pm1..pm3=5 -> bit_out 1,0,1,1,0,0 on consecutive cycles from E+8, done at E+14.
- Start-state selection: TERMINATED=0, pm={7,3,3,9} -> state 1 chosen (tie goes to the lower index). Repeat with TERMINATED=1 -> state 0 regardless of metrics.
- Overflow: DEPTH=4, send 6 dec_valid, last on sixth -> err=1, exactly 4 bits out, err stays 1 until the next accepted st.
- Protocol abuse: st pulses during TRACE, and dec_valid gaps (idle cycles) inside COLLECT -> no effect on output; result is identical to the gap-free run.
